// File: rtl/cla_seq_ctrl.sv
// Multi-cycle wide adder/subtractor: one CHUNK-bit carry-lookahead slice is reused
// for NCHUNK cycles, LSB chunk first, with the inter-slice carry held in a register.

module cla_slice #(
   parameter int N = 8
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         c_i,
   output logic [N-1:0] s_o,
   output logic         c_o
);

   logic [N-1:0] g;
   logic [N-1:0] p;
   logic [N:0]   c;

   // Each carry is a flat sum-of-products of generate/propagate terms, not a ripple chain.
   function automatic logic [N:0] lookahead(input logic [N-1:0] gg,
                                            input logic [N-1:0] pp,
                                            input logic         ci);
      logic [N:0] cc;
      logic       run_p;
      cc    = '0;
      cc[0] = ci;
      for (int i = 0; i < N; i++) begin
         run_p = 1'b1;
         for (int j = i; j >= 0; j--) begin
            cc[i+1] = cc[i+1] | (gg[j] & run_p);
            run_p   = run_p & pp[j];
         end
         cc[i+1] = cc[i+1] | (run_p & ci);
      end
      return cc;
   endfunction

   assign g   = a_i & b_i;
   assign p   = a_i ^ b_i;
   assign c   = lookahead(g, p, c_i);
   assign s_o = p ^ c[N-1:0];
   assign c_o = c[N];

endmodule

module cla_seq_ctrl #(
   parameter  int CHUNK  = 8,
   parameter  int NCHUNK = 4,
   parameter  int IDXW   = 2,
   localparam int W      = CHUNK * NCHUNK
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         sub,
   input  logic         cin,
   input  logic [W-1:0] x,
   input  logic [W-1:0] y,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         ovf
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IDXW-1:0]  idx_q, idx_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     xr_q, xr_d;
   logic [W-1:0]     yr_q, yr_d;
   logic [W-1:0]     sum_q, sum_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [CHUNK-1:0] sl_a, sl_b, sl_s;
   logic             sl_co;
   logic             last;

   assign sl_a = xr_q[idx_q*CHUNK +: CHUNK];
   assign sl_b = yr_q[idx_q*CHUNK +: CHUNK];
   assign last = (idx_q == IDXW'(NCHUNK - 1));

   cla_slice #(.N(CHUNK)) u_slice (
      .a_i (sl_a),
      .b_i (sl_b),
      .c_i (carry_q),
      .s_o (sl_s),
      .c_o (sl_co)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      xr_d    = xr_q;
      yr_d    = yr_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
      ovf_d   = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               // Subtraction is x + ~y + 1, so the inversion and the +1 happen at latch time.
               xr_d    = x;
               yr_d    = sub ? ~y : y;
               carry_d = sub ? 1'b1 : cin;
               idx_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            sum_d[idx_q*CHUNK +: CHUNK] = sl_s;
            carry_d = sl_co;
            idx_d   = idx_q + 1'b1;
            if (last) begin
               cout_d  = sl_co;
               ovf_d   = sl_co ^ (xr_q[W-1] ^ yr_q[W-1] ^ sl_s[CHUNK-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            idx_d   = '0;
            state_d = IDLE;
         end
         default: begin
            idx_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         xr_q    <= '0;
         yr_q    <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         xr_q    <= xr_d;
         yr_q    <= yr_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = (state_q == DONE);
   assign sum  = sum_q;
   assign cout = cout_q;
   assign ovf  = ovf_q;

endmodule
